// File: rtl/hex_rom_loader.sv
// Streams an ioctl download into program ROM: binary images byte-for-byte, or
// Intel HEX images parsed (types 00/01/02/04) with checksum and sticky status.
module hex_rom_loader #(
    parameter int        AW        = 15,
    parameter int        IOCTL_AW  = 15,
    parameter logic [7:0] BIN_INDEX = 8'd0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [7:0]          ioctl_index,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                wr,
    output logic [AW-1:0]       wr_addr,
    output logic [7:0]          wr_data,
    output logic                done,
    output logic                err_checksum,
    output logic                err_syntax,
    output logic                err_range
);

    // state  | meaning
    // S_IDLE | waiting for ':' (everything else ignored)
    // S_LEN  | two digits of byte count
    // S_OFS  | four digits of 16-bit offset (two bytes, cnt selects)
    // S_TYPE | two digits of record type
    // S_DATA | 2*LEN digits of payload
    // S_CSUM | two digits of checksum, then record is committed
    // S_HALT | EOF seen, all input ignored until next download
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_OFS, S_TYPE, S_DATA, S_CSUM, S_HALT} state_t;

    state_t       state_q, state_d, cur;
    logic         phase_q, phase_d, cnt_q, cnt_d, dl_q;
    logic [3:0]   hi_q, hi_d;
    logic [7:0]   len_q, len_d, type_q, type_d, idx_q, idx_d, sum_q, sum_d;
    logic [15:0]  ofs_q, ofs_d, data16_q, data16_d;
    logic [31:0]  base_q, base_d;
    logic         wr_d, done_d, ck_d, sx_d, rg_d;
    logic [AW-1:0] wr_addr_d;
    logic [7:0]   wr_data_d;

    logic         rise, fall, bin_mode, hex_ok;
    logic [3:0]   nib;
    logic [7:0]   b;
    logic [31:0]  addr_in, addr_hex;

    always_comb begin
        hex_ok = 1'b1;
        nib    = 4'h0;
        if (ioctl_dout >= "0" && ioctl_dout <= "9")      nib = 4'(ioctl_dout - "0");
        else if (ioctl_dout >= "A" && ioctl_dout <= "F") nib = 4'(ioctl_dout - "A" + 8'd10);
        else if (ioctl_dout >= "a" && ioctl_dout <= "f") nib = 4'(ioctl_dout - "a" + 8'd10);
        else                                             hex_ok = 1'b0;
    end

    assign rise     = ioctl_download & ~dl_q;
    assign fall     = ~ioctl_download & dl_q;
    assign bin_mode = (ioctl_index == BIN_INDEX);
    assign addr_in  = 32'(ioctl_addr);
    assign b        = {hi_q, nib};
    assign addr_hex = base_q + {16'h0, ofs_q} + {24'h0, idx_q};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        len_d     = len_q;
        type_d    = type_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        ofs_d     = ofs_q;
        data16_d  = data16_q;
        base_d    = base_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        done_d    = done;
        ck_d      = err_checksum;
        sx_d      = err_syntax;
        rg_d      = err_range;
        cur       = state_q;

        if (rise) begin
            done_d  = 1'b0;
            ck_d    = 1'b0;
            sx_d    = 1'b0;
            rg_d    = 1'b0;
            base_d  = 32'h0;
            state_d = S_IDLE;
            phase_d = 1'b0;
            cur     = S_IDLE;
        end

        if (ioctl_download && ioctl_wr) begin
            if (bin_mode) begin
                if ((addr_in >> AW) != 32'h0) begin
                    rg_d = 1'b1;
                end else begin
                    wr_d      = 1'b1;
                    wr_addr_d = addr_in[AW-1:0];
                    wr_data_d = ioctl_dout;
                end
            end else if (cur == S_IDLE) begin
                if (ioctl_dout == ":") begin
                    state_d = S_LEN;
                    sum_d   = 8'h0;
                    phase_d = 1'b0;
                    cnt_d   = 1'b0;
                end
            end else if (cur != S_HALT) begin
                if (!hex_ok) begin
                    sx_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (!phase_q) begin
                    hi_d    = nib;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    sum_d   = sum_q + b;
                    unique case (cur)
                        S_LEN: begin
                            len_d   = b;
                            idx_d   = 8'h0;
                            cnt_d   = 1'b0;
                            state_d = S_OFS;
                        end
                        S_OFS: begin
                            ofs_d = {ofs_q[7:0], b};
                            cnt_d = 1'b1;
                            if (cnt_q) state_d = S_TYPE;
                        end
                        S_TYPE: begin
                            type_d   = b;
                            data16_d = 16'h0;
                            state_d  = (len_q == 8'h0) ? S_CSUM : S_DATA;
                        end
                        S_DATA: begin
                            data16_d = {data16_q[7:0], b};
                            if (type_q == 8'h00) begin
                                if ((addr_hex >> AW) != 32'h0) begin
                                    rg_d = 1'b1;
                                end else begin
                                    wr_d      = 1'b1;
                                    wr_addr_d = addr_hex[AW-1:0];
                                    wr_data_d = b;
                                end
                            end
                            idx_d = idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) state_d = S_CSUM;
                        end
                        S_CSUM: begin
                            state_d = S_IDLE;
                            // Length of 02/04 records is malformed regardless of checksum outcome.
                            if ((type_q == 8'h02 || type_q == 8'h04) && len_q != 8'd2) sx_d = 1'b1;
                            if (sum_q + b != 8'h0) begin
                                ck_d = 1'b1;
                            end else if (type_q == 8'h01) begin
                                done_d  = 1'b1;
                                state_d = S_HALT;
                            end else if (type_q == 8'h02 && len_q == 8'd2) begin
                                base_d = {12'h0, data16_q, 4'h0};
                            end else if (type_q == 8'h04 && len_q == 8'd2) begin
                                base_d = {data16_q, 16'h0};
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end

        if (fall && bin_mode) done_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            cnt_q        <= 1'b0;
            hi_q         <= 4'h0;
            len_q        <= 8'h0;
            type_q       <= 8'h0;
            idx_q        <= 8'h0;
            sum_q        <= 8'h0;
            ofs_q        <= 16'h0;
            data16_q     <= 16'h0;
            base_q       <= 32'h0;
            dl_q         <= 1'b0;
            wr           <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 8'h0;
            done         <= 1'b0;
            err_checksum <= 1'b0;
            err_syntax   <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            len_q        <= len_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            ofs_q        <= ofs_d;
            data16_q     <= data16_d;
            base_q       <= base_d;
            dl_q         <= ioctl_download;
            wr           <= wr_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            done         <= done_d;
            err_checksum <= ck_d;
            err_syntax   <= sx_d;
            err_range    <= rg_d;
        end
    end

endmodule

// File: tb/tb_hex_rom_loader.sv
// Bench for hex_rom_loader: binary and HEX vector tables with a write scoreboard,
// plus hand-written sequences for download edges and reset inside a record.
module tb_hex_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset, ioctl_download, ioctl_wr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [14:0] ioctl_addr;
    logic        wr, done, err_checksum, err_syntax, err_range;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr17, done17, ck17, sx17, rg17;
    logic [16:0] wr_addr17;
    logic [7:0]  wr_data17;

    hex_rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
        .err_checksum(err_checksum), .err_syntax(err_syntax), .err_range(err_range)
    );

    hex_rom_loader #(.AW(17)) dut17 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .wr(wr17), .wr_addr(wr_addr17), .wr_data(wr_data17), .done(done17),
        .err_checksum(ck17), .err_syntax(sx17), .err_range(rg17)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wrec_t;

    wrec_t obs[256];
    wrec_t obs17[256];
    int    obs_n = 0;
    int    obs17_n = 0;

    always @(negedge clk_sys) begin
        if (wr && obs_n < 256) begin
            obs[obs_n] <= '{17'(wr_addr), wr_data, cyc};
            obs_n      <= obs_n + 1;
        end
        if (wr17 && obs17_n < 256) begin
            obs17[obs17_n] <= '{wr_addr17, wr_data17, cyc};
            obs17_n        <= obs17_n + 1;
        end
    end

    wrec_t exp_q[$];
    int    rd = 0;
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input int gap, output int stamp);
        @(posedge clk_sys);
        #1;
        ioctl_dout = c;
        ioctl_wr   = 1'b1;
        stamp      = cyc;
        @(posedge clk_sys);
        #1;
        ioctl_wr   = 1'b0;
        ioctl_addr = ioctl_addr + 15'd1;
        if (gap > 0) idle(gap);
    endtask

    task automatic drain(input string tag);
        wrec_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " write present"}, 32'(rd < obs_n), 32'd1);
            if (rd < obs_n) begin
                check({tag, " addr"}, 32'(obs[rd].addr), 32'(e.addr));
                check({tag, " data"}, 32'(obs[rd].data), 32'(e.data));
                check({tag, " latency"}, 32'(obs[rd].cyc), 32'(e.cyc));
                rd++;
            end
        end
        check({tag, " extra writes"}, 32'(obs_n - rd), 32'd0);
        rd = obs_n;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] f);
        check({tag, " flags{done,ck,sx,rg}"}, 32'({done, err_checksum, err_syntax, err_range}), 32'(f));
    endtask

    task automatic send_line(input string s, input int n, input logic [16:0] a0,
                             input logic [31:0] bytes, input int gap);
        int st;
        for (int k = 0; k < s.len(); k++) begin
            send_char(s[k], gap, st);
            if (k >= 10 && ((k - 10) % 2) == 0 && ((k - 10) / 2) < n) begin
                int i;
                i = (k - 10) / 2;
                exp_q.push_back('{a0 + 17'(i), bytes[31 - 8*i -: 8], st + 1});
            end
        end
        send_char(8'h0D, 0, st);
        send_char(8'h0A, 0, st);
    endtask

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        int          gap;
    } bin_vec_t;

    typedef struct {
        string       line;
        int          n;
        logic [16:0] a0;
        logic [31:0] bytes;
        int          gap;
        logic [3:0]  flags;
        bit          chk17;
    } hex_vec_t;

    bin_vec_t bvec[4];
    hex_vec_t hvec[10];

    initial begin
        int st;
        int before17;

        bvec[0] = '{15'h0000, 8'hAA, 0};
        bvec[1] = '{15'h0001, 8'h55, 2};
        bvec[2] = '{15'h7FFF, 8'h3C, 0};
        bvec[3] = '{15'h0100, 8'h00, 1};

        hvec[0] = '{":0400100001020304E2", 4, 17'h10, 32'h01020304, 0, 4'b0000, 1'b0};
        hvec[1] = '{":01000500ee0c",       1, 17'h05, 32'hEE000000, 2, 4'b0000, 1'b0};
        hvec[2] = '{":020000040001F9",     0, 17'h00, 32'h0,        0, 4'b0000, 1'b0};
        hvec[3] = '{":01000000AA55",       0, 17'h00, 32'h0,        0, 4'b0001, 1'b1};
        hvec[4] = '{":020000040000FA",     0, 17'h00, 32'h0,        0, 4'b0001, 1'b0};
        hvec[5] = '{":0G",                 0, 17'h00, 32'h0,        0, 4'b0011, 1'b0};
        hvec[6] = '{":01000500EE0C",       1, 17'h05, 32'hEE000000, 1, 4'b0011, 1'b0};
        hvec[7] = '{":0400100001020304E3", 4, 17'h10, 32'h01020304, 0, 4'b0111, 1'b0};
        hvec[8] = '{":00000001FF",         0, 17'h00, 32'h0,        0, 4'b1111, 1'b0};
        hvec[9] = '{":010000007788",       0, 17'h00, 32'h0,        0, 4'b1111, 1'b0};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 15'h0;
        ioctl_dout     = 8'h0;
        idle(3);
        check("reset wr", 32'(wr), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check_flags("reset", 4'b0000);
        reset = 1'b0;
        idle(1);

        // inputs with download low must be ignored
        send_char(8'h77, 1, st);
        drain("no download");

        ioctl_download = 1'b1;
        idle(1);
        for (int v = 0; v < 4; v++) begin
            ioctl_addr = bvec[v].addr;
            send_char(bvec[v].data, bvec[v].gap, st);
            exp_q.push_back('{17'(bvec[v].addr), bvec[v].data, st + 1});
        end
        idle(2);
        drain("bin");
        check_flags("bin active", 4'b0000);

        // strobe coinciding with the falling edge is dropped
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 15'h0002;
        ioctl_dout     = 8'h99;
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        idle(2);
        drain("bin fall");
        check_flags("bin done", 4'b1000);

        ioctl_index    = 8'd1;
        ioctl_addr     = 15'h0;
        ioctl_download = 1'b1;
        idle(2);
        check_flags("hex start", 4'b0000);
        for (int v = 0; v < 10; v++) begin
            before17 = obs17_n;
            send_line(hvec[v].line, hvec[v].n, hvec[v].a0, hvec[v].bytes, hvec[v].gap);
            idle(3);
            drain($sformatf("hex%0d", v));
            check_flags($sformatf("hex%0d", v), hvec[v].flags);
            if (hvec[v].chk17) begin
                check("aw17 write count", 32'(obs17_n - before17), 32'd1);
                check("aw17 addr", 32'(obs17[before17].addr), 32'h10000);
                check("aw17 data", 32'(obs17[before17].data), 32'hAA);
                check("aw17 err_range", 32'(rg17), 32'd0);
            end
        end

        // new download clears sticky flags
        ioctl_download = 1'b0;
        idle(2);
        ioctl_download = 1'b1;
        idle(2);
        check_flags("hex restart", 4'b0000);
        send_line(":0400100001020304E3", 4, 17'h10, 32'h01020304, 0);
        idle(3);
        drain("csum again");
        check_flags("csum again", 4'b0100);

        // reset between digits of a data byte abandons the record
        send_char(":", 0, st);
        send_char("0", 0, st);
        send_char("1", 0, st);
        for (int k = 0; k < 4; k++) send_char(k == 3 ? "5" : "0", 0, st);
        send_char("0", 0, st);
        send_char("0", 0, st);
        send_char("E", 0, st);
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        idle(1);
        check("mid reset wr", 32'(wr), 32'd0);
        check_flags("mid reset", 4'b0000);
        reset = 1'b0;
        send_char("E", 0, st);
        send_char("0", 0, st);
        send_char("C", 0, st);
        idle(3);
        drain("after reset");
        check_flags("after reset", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
